voice_frame_scheduler: RTL and testbench
========================================

Name: voice_frame_scheduler

Overview:
Per-sample controller that time-shares one partial-synthesis datapath across NUM_VOICES oscillator voices. At a fixed point in every sample period it issues one request per voice, sums the returned signed contributions, and produces one saturated mixed sample per period. It sits between the sample-period counter (its sample_cycle_count input) and the audio output path.

Parameters:
NUM_VOICES, 64, voices sequenced per sample frame (>=2)
VOICE_W, $clog2(NUM_VOICES), voice index width
DATA_W, 18, signed width of one voice contribution
OUT_W, 24, signed width of mixed output sample
START_OFFSET, 0, sample_cycle_count value that starts a frame
ACC_W, DATA_W+VOICE_W+1, internal accumulator width (derived)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
sample_cycle_count  in  12  position within current sample period
enable  in  1  permits new frames to start
req_valid  out  1  request to datapath valid
req_voice  out  VOICE_W  voice index of request
req_ready  in  1  datapath accepts request
resp_valid  in  1  datapath contribution valid (in-order, never stalled)
resp_data  in  DATA_W  signed contribution
flush  out  1  one-cycle pulse: datapath drops all in-flight work
sample_out  out  OUT_W  signed mixed sample, held between updates
sample_valid  out  1  one-cycle pulse when sample_out updates
busy  out  1  frame in progress (state != IDLE)
overrun  out  1  sticky: a frame start arrived before previous frame finished

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; req_valid=0, req_voice=0, flush=0, sample_out=0, sample_valid=0, busy=0, overrun=0; accumulator, issue index, response count cleared. Applies mid-frame; no partial sample emitted.
- start = enable && (sample_cycle_count == START_OFFSET); single-cycle event per period.
- States: IDLE, ISSUE, DRAIN.
- IDLE: on start -> ISSUE; idx=0, acc=0, resp_cnt=0. resp_valid ignored.
- ISSUE: req_valid=1, req_voice=idx. req_voice stable while req_valid && !req_ready. On req_ready: if idx==NUM_VOICES-1 -> DRAIN (req_valid=0 next cycle) else idx++.
- Responses accepted in ISSUE and DRAIN: acc += sign-extend(resp_data) to ACC_W; resp_cnt++. Responses beyond NUM_VOICES ignored.
- Completion: cycle resp_cnt reaches NUM_VOICES (counting the response in that cycle) -> next edge: sample_out=sat(final acc), sample_valid=1 for one cycle, state IDLE. Completion can occur from ISSUE if last accept and last response coincide. Latency: sample_valid exactly 1 cycle after last response.
- Saturation: acc > 2^(OUT_W-1)-1 -> max; acc < -2^(OUT_W-1) -> min; else exact value. If OUT_W >= ACC_W, plain sign-extension.
- Overrun: start while state != IDLE -> overrun=1 (cleared only by reset), flush=1 for one cycle, frame abandoned (no sample_valid, sample_out held), restart ISSUE at idx=0 with acc, resp_cnt cleared. resp_valid in that cycle discarded.
- Start coinciding with completion cycle: completion wins (sample emitted), then start is an overrun only if state != IDLE; since completion returns to IDLE the same edge, treat as overrun: flush, restart, but sample still emitted.
- enable=0: blocks new frames only; frame in progress completes.
- busy = (state != IDLE).

Test Plan:
1. NUM_VOICES=4, req_ready=1, 3-cycle datapath returning 100,200,-50,25 -> req_voice 0,1,2,3 on consecutive cycles; sample_out=275, one sample_valid pulse 1 cycle after 4th response; busy low afterwards.
2. Backpressure: req_ready random 50% -> each voice 0..3 accepted exactly once in order; req_voice never changes while stalled; sum still correct.
3. Saturation, OUT_W=16, DATA_W=16, 4 voices: all 32767 -> sample_out=32767; all -32768 -> -32768; mix 32767,-32768,1,0 -> 0.
4. Overrun: hold req_ready=0 across next start -> overrun=1, flush pulse 1 cycle, req_voice restarts at 0, no sample_valid for aborted frame, sample_out retains prior value; overrun stays 1 after later normal frames.
5. Reset mid-frame: rst_n=0 during ISSUE at idx=2 -> next edge all outputs at reset values (sample_out=0, overrun=0); next start runs clean frame.
6. enable=0 at start -> no req_valid that period; enable dropped mid-frame -> frame completes with correct sample, no following frame.

Source files
------------

// File: rtl/voice_frame_scheduler.sv
// Time-shares one partial-synthesis datapath across NUM_VOICES voices per sample
// period, accumulating the signed contributions into one saturated mixed sample.
module voice_frame_scheduler #(
  parameter int NUM_VOICES   = 64,
  parameter int VOICE_W      = $clog2(NUM_VOICES),
  parameter int DATA_W       = 18,
  parameter int OUT_W        = 24,
  parameter int START_OFFSET = 0,
  parameter int ACC_W        = DATA_W + VOICE_W + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [11:0]              sample_cycle_count,
  input  logic                     enable,
  output logic                     req_valid,
  output logic [VOICE_W-1:0]       req_voice,
  input  logic                     req_ready,
  input  logic                     resp_valid,
  input  logic signed [DATA_W-1:0] resp_data,
  output logic                     flush,
  output logic signed [OUT_W-1:0]  sample_out,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CNT_W = VOICE_W + 1;
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [11:0]          START_CNT = 12'(START_OFFSET);
  localparam logic [VOICE_W-1:0]   LAST_IDX  = VOICE_W'(NUM_VOICES - 1);
  localparam logic [CNT_W-1:0]     FULL_CNT  = CNT_W'(NUM_VOICES);
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Clamp to the output range; degenerates to sign extension when OUT_W >= ACC_W.
  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [EXT_W-1:0] ve;
    ve = EXT_W'(v);
    if (ve > SAT_MAX) begin
      return SAT_MAX[OUT_W-1:0];
    end else if (ve < SAT_MIN) begin
      return SAT_MIN[OUT_W-1:0];
    end else begin
      return ve[OUT_W-1:0];
    end
  endfunction

  state_t                     state, state_nx;
  logic [VOICE_W-1:0]         idx, idx_nx;
  logic signed [ACC_W-1:0]    acc, acc_nx, acc_sum, resp_ext;
  logic [CNT_W-1:0]           resp_cnt, cnt_nx, cnt_inc;
  logic                       flush_nx, sample_valid_nx, overrun_nx;
  logic signed [OUT_W-1:0]    sample_out_nx;
  logic                       start_evt, resp_take, done;

  assign req_voice = idx;
  assign start_evt = enable && (sample_cycle_count == START_CNT);
  assign resp_ext  = ACC_W'(resp_data);
  assign acc_sum   = acc + resp_ext;
  assign cnt_inc   = resp_cnt + CNT_W'(1);
  assign resp_take = resp_valid && (state != IDLE) && (resp_cnt < FULL_CNT);
  assign done      = resp_take && (cnt_inc == FULL_CNT);

  // Next-state, accumulation, completion and overrun handling.
  always_comb begin
    state_nx        = state;
    idx_nx          = idx;
    acc_nx          = acc;
    cnt_nx          = resp_cnt;
    flush_nx        = 1'b0;
    sample_valid_nx = 1'b0;
    sample_out_nx   = sample_out;
    overrun_nx      = overrun;

    case (state)
      IDLE: begin
        if (start_evt) begin
          state_nx = ISSUE;
          idx_nx   = '0;
          acc_nx   = '0;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        if (req_ready) begin
          if (idx == LAST_IDX) begin
            state_nx = DRAIN;
          end else begin
            idx_nx = idx + VOICE_W'(1);
          end
        end else begin
          state_nx = ISSUE;
        end
      end
      DRAIN: begin
        state_nx = DRAIN;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (state != IDLE) begin
      if (resp_take) begin
        acc_nx = acc_sum;
        cnt_nx = cnt_inc;
      end else begin
        acc_nx = acc;
      end
      if (done) begin
        sample_out_nx   = saturate(acc_sum);
        sample_valid_nx = 1'b1;
        state_nx        = IDLE;
      end else begin
        sample_valid_nx = 1'b0;
      end
      // A start during a frame abandons it; a coincident completion still emits.
      if (start_evt) begin
        overrun_nx = 1'b1;
        flush_nx   = 1'b1;
        state_nx   = ISSUE;
        idx_nx     = '0;
        acc_nx     = '0;
        cnt_nx     = '0;
      end else begin
        overrun_nx = overrun;
      end
    end else begin
      overrun_nx = overrun;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      acc          <= '0;
      resp_cnt     <= '0;
      flush        <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      req_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      acc          <= acc_nx;
      resp_cnt     <= cnt_nx;
      flush        <= flush_nx;
      sample_out   <= sample_out_nx;
      sample_valid <= sample_valid_nx;
      overrun      <= overrun_nx;
      req_valid    <= (state_nx == ISSUE);
      busy         <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_voice_frame_scheduler.sv
// Directed bench for voice_frame_scheduler: 4 voices, 16-bit data and output,
// a 3-cycle in-order datapath model driven from the stimulus process.
module tb_voice_frame_scheduler;

  localparam int NV = 4;

  logic               clk;
  logic               rst_n;
  logic [11:0]        scc;
  logic               enable;
  logic               req_valid;
  logic [1:0]         req_voice;
  logic               req_ready;
  logic               resp_valid;
  logic signed [15:0] resp_data;
  logic               flush;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               busy;
  logic               overrun;

  int total = 0;
  int bad   = 0;

  logic [2:0]         pv;
  logic signed [15:0] pd [3];
  logic signed [15:0] vals [NV];
  logic               rv, rr, done;
  logic [1:0]         v0;
  int                 nexp;

  voice_frame_scheduler #(
    .NUM_VOICES(NV), .DATA_W(16), .OUT_W(16), .START_OFFSET(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_cycle_count(scc), .enable(enable),
    .req_valid(req_valid), .req_voice(req_voice), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush),
    .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: datapath model accepts/shifts, flush drops in-flight work.
  task automatic tick();
    logic f, fl;
    logic [1:0] v;
    f  = (req_valid === 1'b1) && (req_ready === 1'b1);
    fl = (flush === 1'b1);
    v  = req_voice;
    @(posedge clk);
    #1;
    pv    = fl ? {2'b00, f} : {pv[1:0], f};
    pd[2] = pd[1];
    pd[1] = pd[0];
    pd[0] = vals[v];
    resp_valid = pv[2];
    resp_data  = pd[2];
  endtask

  task automatic pulse();
    scc = 12'd5;
    tick();
    scc = 12'd0;
  endtask

  task automatic wait_sample(input string tag, input logic signed [31:0] exp);
    int n;
    n = 0;
    while (sample_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, sample_valid, 1);
    chk(tag, sample_out, exp);
    tick();
    chk({tag, "_pulse"}, sample_valid, 0);
  endtask

  task automatic set_vals(input logic signed [15:0] a, b, c, d);
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
  endtask

  initial begin
    rst_n = 1'b0; scc = 12'd0; enable = 1'b0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_data = 16'sd0; pv = 3'b000;
    pd[0] = 16'sd0; pd[1] = 16'sd0; pd[2] = 16'sd0;
    set_vals(16'sd0, 16'sd0, 16'sd0, 16'sd0);
    tick();
    tick();
    chk("rst_req_valid", req_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sample_out", sample_out, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_flush", flush, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    tick();

    // Basic frame: 100 + 200 - 50 + 25 = 275
    set_vals(16'sd100, 16'sd200, -16'sd50, 16'sd25);
    req_ready = 1'b1;
    pulse();
    chk("t1_busy", busy, 1);
    chk("t1_req_valid", req_valid, 1);
    chk("t1_voice0", req_voice, 0);
    for (int i = 1; i < NV; i++) begin
      tick();
      chk("t1_voice", req_voice, i);
    end
    tick();
    chk("t1_drain_req", req_valid, 0);
    chk("t1_drain_busy", busy, 1);
    tick();
    tick();
    chk("t1_early_valid", sample_valid, 0);
    tick();
    chk("t1_valid", sample_valid, 1);
    chk("t1_sum", sample_out, 275);
    chk("t1_idle", busy, 0);
    tick();
    chk("t1_pulse", sample_valid, 0);
    chk("t1_hold", sample_out, 275);

    // Random backpressure: 1000 - 3000 + 7 - 1 = -1994
    set_vals(16'sd1000, -16'sd3000, 16'sd7, -16'sd1);
    req_ready = 1'b0;
    pulse();
    nexp = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      req_ready = 1'($urandom_range(0, 1));
      rv = req_valid;
      rr = req_ready;
      v0 = req_voice;
      tick();
      if (rv && rr) begin
        chk("bp_order", v0, nexp);
        nexp++;
      end else if (rv && req_valid) begin
        chk("bp_hold", req_voice, v0);
      end
      if (sample_valid === 1'b1) done = 1'b1;
    end
    chk("bp_done", sample_valid, 1);
    chk("bp_count", nexp, NV);
    chk("bp_sum", sample_out, -1994);
    tick();

    // Saturation at 16-bit output
    req_ready = 1'b1;
    set_vals(16'sd32767, -16'sd32768, 16'sd1, 16'sd0);
    pulse();
    wait_sample("sat_mix", 0);
    set_vals(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768);
    pulse();
    wait_sample("sat_min", -32768);
    set_vals(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767);
    pulse();
    wait_sample("sat_max", 32767);

    // Overrun: two voices issued, then stalled across the next start
    set_vals(16'sd1, 16'sd2, 16'sd3, 16'sd4);
    pulse();
    tick();
    tick();
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("ov_busy", busy, 1);
    chk("ov_stalled_voice", req_voice, 2);
    chk("ov_pre_flag", overrun, 0);
    pulse();
    chk("ov_flag", overrun, 1);
    chk("ov_flush", flush, 1);
    chk("ov_restart_voice", req_voice, 0);
    chk("ov_req_valid", req_valid, 1);
    chk("ov_no_sample", sample_valid, 0);
    chk("ov_held", sample_out, 32767);
    tick();
    chk("ov_flush_pulse", flush, 0);
    chk("ov_sticky1", overrun, 1);
    req_ready = 1'b1;
    wait_sample("ov_restart_sum", 10);
    pulse();
    wait_sample("ov_next_sum", 10);
    chk("ov_sticky2", overrun, 1);

    // Reset in the middle of issuing
    set_vals(16'sd10, 16'sd20, 16'sd30, 16'sd40);
    pulse();
    tick();
    tick();
    chk("mr_voice2", req_voice, 2);
    rst_n = 1'b0;
    tick();
    chk("mr_req_valid", req_valid, 0);
    chk("mr_voice", req_voice, 0);
    chk("mr_flush", flush, 0);
    chk("mr_sample_out", sample_out, 0);
    chk("mr_sample_valid", sample_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_overrun", overrun, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("mr_stale_busy", busy, 0);
    chk("mr_stale_valid", sample_valid, 0);
    pulse();
    wait_sample("mr_clean", 100);

    // Enable gating
    enable = 1'b0;
    pulse();
    chk("en_off_busy", busy, 0);
    chk("en_off_req", req_valid, 0);
    set_vals(16'sd5, 16'sd6, 16'sd7, 16'sd8);
    enable = 1'b1;
    pulse();
    tick();
    enable = 1'b0;
    wait_sample("en_drop", 26);
    pulse();
    tick();
    chk("en_no_next_busy", busy, 0);
    chk("en_no_next_req", req_valid, 0);
    chk("en_overrun_clear", overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
